// File: rtl/aha_pmu_wic_responder_if.sv
// WIC handshake bundle between the platform controller (master) and the PMU responder (slave).
interface aha_pmu_wic_responder_if #(
    parameter int unsigned NUM_IRQ = 32
) ();
    logic               PMU_WIC_EN_REQ;
    logic               SLEEPDEEP;
    logic [NUM_IRQ-1:0] WIC_MASK;
    logic [NUM_IRQ-1:0] IRQ;
    logic               NMI;
    logic               PMU_WIC_EN_ACK;
    logic               PMU_WAKEUP;
    logic               WIC_ARMED;
    logic               PROTO_ERR;

    modport master (
        output PMU_WIC_EN_REQ, SLEEPDEEP, WIC_MASK, IRQ, NMI,
        input  PMU_WIC_EN_ACK, PMU_WAKEUP, WIC_ARMED, PROTO_ERR
    );

    modport slave (
        input  PMU_WIC_EN_REQ, SLEEPDEEP, WIC_MASK, IRQ, NMI,
        output PMU_WIC_EN_ACK, PMU_WAKEUP, WIC_ARMED, PROTO_ERR
    );
endinterface

// File: rtl/aha_pmu_wic_responder.sv
// PMU-side WIC enable responder: delayed 4-phase REQ/ACK, mask snapshot on arm,
// and deep-sleep wake detection reported back to the platform controller.
module aha_pmu_wic_responder #(
    parameter int unsigned ACK_DELAY = 4,
    parameter int unsigned NUM_IRQ   = 32
) (
    input  logic                      MASTER_CLK,
    input  logic                      PORESETn,
    aha_pmu_wic_responder_if.slave    wic
);
    localparam int unsigned CNT_W = $clog2(ACK_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_DELAY - 1);

    typedef enum logic [1:0] {StIdle, StArming, StArmed, StDisarming} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               ack_q, ack_d;
    logic               wake_q, wake_d;
    logic               armed_q, armed_d;
    logic               err_q, err_d;
    logic               wake_evt;

    assign wake_evt = wic.SLEEPDEEP & ((|(wic.IRQ & mask_q)) | wic.NMI);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        ack_d   = ack_q;
        wake_d  = wake_q;
        err_d   = err_q;
        if (!wic.SLEEPDEEP) begin
            wake_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (wic.PMU_WIC_EN_REQ) begin
                    state_d = StArming;
                    cnt_d   = CNT_LOAD;
                end
            end
            StArming: begin
                if (!wic.PMU_WIC_EN_REQ) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = StArmed;
                    ack_d   = 1'b1;
                    mask_d  = wic.WIC_MASK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StArmed: begin
                // Set wins over clear; a REQ fall in the same cycle still starts disarm.
                if (wake_evt) begin
                    wake_d = 1'b1;
                end
                if (!wic.PMU_WIC_EN_REQ) begin
                    state_d = StDisarming;
                    cnt_d   = CNT_LOAD;
                end
            end
            StDisarming: begin
                if (wic.PMU_WIC_EN_REQ) begin
                    err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    ack_d   = 1'b0;
                    wake_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                ack_d   = 1'b0;
                wake_d  = 1'b0;
            end
        endcase
        armed_d = (state_d == StArmed);
    end

    always_ff @(posedge MASTER_CLK or negedge PORESETn) begin
        if (!PORESETn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mask_q  <= '0;
            ack_q   <= 1'b0;
            wake_q  <= 1'b0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            ack_q   <= ack_d;
            wake_q  <= wake_d;
            armed_q <= armed_d;
            err_q   <= err_d;
        end
    end

    assign wic.PMU_WIC_EN_ACK = ack_q;
    assign wic.PMU_WAKEUP     = wake_q;
    assign wic.WIC_ARMED      = armed_q;
    assign wic.PROTO_ERR      = err_q;
endmodule

// File: tb/tb_aha_pmu_wic_responder.sv
// Self-checking bench for aha_pmu_wic_responder: directed handshake/wake scenarios
// followed by randomized traffic compared against a deadline-based reference model.
module tb_aha_pmu_wic_responder;
    localparam int unsigned ACK_DELAY = 4;
    localparam int unsigned NUM_IRQ   = 32;

    localparam int PH_IDLE   = 0;
    localparam int PH_ARMING = 1;
    localparam int PH_ARMED  = 2;
    localparam int PH_DISARM = 3;

    logic MASTER_CLK = 1'b0;
    logic PORESETn;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: protocol phase plus the edge number at which the delay expires.
    int                 m_phase;
    int                 m_edge;
    int                 m_due;
    logic [NUM_IRQ-1:0] m_mask;
    logic               m_wake;
    logic               m_err;

    aha_pmu_wic_responder_if #(.NUM_IRQ(NUM_IRQ)) wic ();

    aha_pmu_wic_responder #(
        .ACK_DELAY (ACK_DELAY),
        .NUM_IRQ   (NUM_IRQ)
    ) dut (
        .MASTER_CLK (MASTER_CLK),
        .PORESETn   (PORESETn),
        .wic        (wic)
    );

    always #5 MASTER_CLK = ~MASTER_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_edge  = 0;
        m_due   = 0;
        m_mask  = '0;
        m_wake  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        logic req, sd, wake;
        req  = wic.PMU_WIC_EN_REQ;
        sd   = wic.SLEEPDEEP;
        wake = sd && ((|(wic.IRQ & m_mask)) || wic.NMI);
        m_edge++;
        if (!sd) m_wake = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                if (req) begin
                    m_phase = PH_ARMING;
                    m_due   = m_edge + ACK_DELAY;
                end
            end
            PH_ARMING: begin
                if (!req) begin
                    m_phase = PH_IDLE;
                    m_err   = 1'b1;
                end else if (m_edge == m_due) begin
                    m_phase = PH_ARMED;
                    m_mask  = wic.WIC_MASK;
                end
            end
            PH_ARMED: begin
                if (wake) m_wake = 1'b1;
                if (!req) begin
                    m_phase = PH_DISARM;
                    m_due   = m_edge + ACK_DELAY;
                end
            end
            default: begin
                if (req) m_err = 1'b1;
                if (m_edge == m_due) begin
                    m_phase = PH_IDLE;
                    m_wake  = 1'b0;
                end
            end
        endcase
    endtask

    task automatic compare_model();
        check("ack", 32'(wic.PMU_WIC_EN_ACK),
              32'(m_phase == PH_ARMED || m_phase == PH_DISARM));
        check("wakeup", 32'(wic.PMU_WAKEUP), 32'(m_wake));
        check("armed", 32'(wic.WIC_ARMED), 32'(m_phase == PH_ARMED));
        check("proto_err", 32'(wic.PROTO_ERR), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge MASTER_CLK);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 32'(wic.PMU_WIC_EN_ACK), 32'd0);
        check({tag, "_wakeup"}, 32'(wic.PMU_WAKEUP), 32'd0);
        check({tag, "_armed"}, 32'(wic.WIC_ARMED), 32'd0);
        check({tag, "_proto_err"}, 32'(wic.PROTO_ERR), 32'd0);
    endtask

    initial begin
        // Reset held with every input pushing toward activity.
        PORESETn           = 1'b0;
        wic.PMU_WIC_EN_REQ = 1'b1;
        wic.SLEEPDEEP      = 1'b1;
        wic.WIC_MASK       = '1;
        wic.IRQ            = '1;
        wic.NMI            = 1'b1;
        model_reset();
        #2;
        check_all_zero("rst_async");
        repeat (3) @(posedge MASTER_CLK);
        #1;
        check_all_zero("rst_held");

        wic.PMU_WIC_EN_REQ = 1'b0;
        wic.SLEEPDEEP      = 1'b0;
        wic.WIC_MASK       = '0;
        wic.IRQ            = '0;
        wic.NMI            = 1'b0;
        #2 PORESETn = 1'b1;
        repeat (3) tick();

        // Handshake latency in both directions.
        wic.PMU_WIC_EN_REQ = 1'b1;
        for (int i = 0; i <= ACK_DELAY; i++) begin
            tick();
            check("hs_ack_rise", 32'(wic.PMU_WIC_EN_ACK), 32'(i == ACK_DELAY));
        end
        repeat (3) tick();
        wic.PMU_WIC_EN_REQ = 1'b0;
        for (int i = 0; i <= ACK_DELAY; i++) begin
            tick();
            check("hs_ack_fall", 32'(wic.PMU_WIC_EN_ACK), 32'(i != ACK_DELAY));
        end
        check("hs_proto_err", 32'(wic.PROTO_ERR), 32'd0);

        // Masked wake using the snapshot, not the live mask.
        wic.WIC_MASK       = 32'h1;
        wic.PMU_WIC_EN_REQ = 1'b1;
        repeat (ACK_DELAY + 1) tick();
        check("mw_armed", 32'(wic.WIC_ARMED), 32'd1);
        wic.WIC_MASK  = '0;
        wic.SLEEPDEEP = 1'b1;
        wic.IRQ       = 32'h2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mw_unmasked_irq", 32'(wic.PMU_WAKEUP), 32'd0);
        end
        wic.IRQ = 32'h1;
        tick();
        check("mw_wake_set", 32'(wic.PMU_WAKEUP), 32'd1);
        wic.IRQ = '0;
        tick();
        check("mw_wake_hold", 32'(wic.PMU_WAKEUP), 32'd1);
        wic.SLEEPDEEP = 1'b0;
        tick();
        check("mw_wake_clr", 32'(wic.PMU_WAKEUP), 32'd0);
        wic.PMU_WIC_EN_REQ = 1'b0;
        repeat (ACK_DELAY + 1) tick();
        check("mw_disarmed", 32'(wic.PMU_WIC_EN_ACK), 32'd0);

        // NMI wakes with an all-zero snapshot, but only in deep sleep.
        wic.PMU_WIC_EN_REQ = 1'b1;
        repeat (ACK_DELAY + 1) tick();
        wic.SLEEPDEEP = 1'b1;
        wic.NMI       = 1'b1;
        tick();
        check("nmi_wake", 32'(wic.PMU_WAKEUP), 32'd1);
        wic.SLEEPDEEP = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("nmi_no_sleep", 32'(wic.PMU_WAKEUP), 32'd0);
        end
        wic.NMI            = 1'b0;
        wic.PMU_WIC_EN_REQ = 1'b0;
        repeat (ACK_DELAY + 1) tick();

        // Abort during arming, then confirm the error flag is sticky.
        wic.PMU_WIC_EN_REQ = 1'b1;
        repeat (2) tick();
        wic.PMU_WIC_EN_REQ = 1'b0;
        tick();
        check("abort_ack", 32'(wic.PMU_WIC_EN_ACK), 32'd0);
        check("abort_armed", 32'(wic.WIC_ARMED), 32'd0);
        check("abort_err", 32'(wic.PROTO_ERR), 32'd1);
        wic.PMU_WIC_EN_REQ = 1'b1;
        repeat (ACK_DELAY + 1) tick();
        check("abort_rearm_ack", 32'(wic.PMU_WIC_EN_ACK), 32'd1);
        wic.PMU_WIC_EN_REQ = 1'b0;
        repeat (ACK_DELAY + 1) tick();
        check("abort_err_sticky", 32'(wic.PROTO_ERR), 32'd1);

        // Asynchronous reset while armed and waking.
        wic.WIC_MASK       = 32'h1;
        wic.PMU_WIC_EN_REQ = 1'b1;
        repeat (ACK_DELAY + 1) tick();
        wic.SLEEPDEEP = 1'b1;
        wic.IRQ       = 32'h1;
        tick();
        check("mid_wake", 32'(wic.PMU_WAKEUP), 32'd1);
        #2 PORESETn = 1'b0;
        model_reset();
        #1;
        check_all_zero("mid_rst");
        #2 PORESETn = 1'b1;
        for (int i = 0; i <= ACK_DELAY; i++) begin
            tick();
            check("mid_rst_ack", 32'(wic.PMU_WIC_EN_ACK), 32'(i == ACK_DELAY));
        end

        // Randomized traffic against the model, with occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 7) == 0) wic.PMU_WIC_EN_REQ = ~wic.PMU_WIC_EN_REQ;
            if ($urandom_range(0, 5) == 0) wic.SLEEPDEEP = ~wic.SLEEPDEEP;
            if ($urandom_range(0, 3) == 0) wic.IRQ = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 9) == 0) wic.WIC_MASK = $urandom & $urandom;
            wic.NMI = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 PORESETn = 1'b0;
                model_reset();
                #1;
                check_all_zero("rnd_rst");
                #2 PORESETn = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
